w1_packer: RTL
==============

W1_PACKER -- requirements
Module: w1_packer

Interface
REQ-001 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Port: rst  in  1  reset, asynchronous, active-high.
REQ-003 Port: sec_lvl  in  3  security level: 3'd2 selects 6-bit packing; 3'd3 and 3'd5 select 4-bit packing; any other value is treated as 3'd2.
REQ-004 Port: valid_i  in  1  upstream coefficient valid.
REQ-005 Port: di  in  24  upstream word; the r1 high-bits coefficient is in di[5:0]; di[23:6] is ignored.
REQ-006 Port: ready_i  out  1  block can accept a coefficient this cycle.
REQ-007 Port: do  out  32  packed output word.
REQ-008 Port: valid_o  out  1  do holds a valid word.
REQ-009 Port: ready_o  in  1  downstream accepts do this cycle.
REQ-010 Port: last_o  out  1  do is the final word of the current polynomial; qualified by valid_o.
REQ-011 Port: err_o  out  1  sticky range-error flag.

Function
REQ-012 The block SHALL SimpleBitPack one 256-coefficient w1 polynomial into 32-bit words, little-endian: coefficient i occupies stream bits [i*w+w-1 : i*w], with w=6 (lvl2) or w=4 (lvl3/5).
REQ-013 Input transfer: valid_i && ready_i at a rising edge; output transfer: valid_o && ready_o at a rising edge.
REQ-014 State: 64-bit accumulator acc, bit count cnt (0..37), coefficient counter ccnt (0..255), word counter wcnt, latched width w, output register do/valid_o/last_o.
REQ-015 ready_i SHALL equal (cnt < 32); it is a function of registers only, with no combinational path from valid_i or ready_o.
REQ-016 On input transfer: acc <= acc | (di[w-1:0] << cnt); cnt <= cnt + w; ccnt <= ccnt + 1, wrapping 255->0.
REQ-017 w SHALL be latched from sec_lvl on the input transfer with ccnt==0 and used for that coefficient; sec_lvl changes mid-polynomial SHALL be ignored until ccnt returns to 0.
REQ-018 Emit: when cnt >= 32 and (!valid_o || ready_o), at the edge: do <= acc[31:0]; valid_o <= 1; acc <= acc >> 32; cnt <= cnt - 32; wcnt increments.
REQ-019 last_o SHALL be 1 with the 48th word (lvl2) or 32nd word (lvl3/5); wcnt then resets to 0. No partial-word flush is needed, since 1536 and 1024 bits are multiples of 32.
REQ-020 An output transfer with no emit in the same cycle SHALL clear valid_o and last_o; do keeps its value.
REQ-021 While valid_o && !ready_o: do, last_o and valid_o SHALL hold stable; acc keeps filling until cnt >= 32, then ready_i drops.
REQ-022 Latency: the edge accepting the coefficient that makes cnt >= 32 is followed by the emit edge one cycle later, provided the output slot is free.
REQ-023 Throughput: input and emit never occur in the same cycle, so lvl3/5 takes 9 cycles per word and lvl2 takes 16 coefficients plus 3 emit cycles per 3 words, without backpressure.
REQ-024 Range check: on input transfer, if di[5:0] > 43 (w=6) or di[5:0] > 15 (w=4), err_o SHALL be set at that edge and remain 1 until reset; packing continues using the low w bits.

Reset
REQ-025 While rst is asserted, acc, cnt, ccnt and wcnt SHALL be 0, w SHALL be 6, and do, valid_o, last_o and err_o SHALL be 0; ready_i is therefore 1.
REQ-026 Reset asserted mid-polynomial SHALL discard all partial data; the first coefficient accepted after reset is coefficient 0 of a new polynomial.

Verification
REQ-027 lvl3, ready_o=1, coefficients i mod 16 (i=0..255) -> 32 words, each alternating 0x76543210 / 0xFEDCBA98; last_o only on word 32; err_o=0.
REQ-028 lvl2, c0=1, c1=2, c5=43, all others 0 -> word0=0xC0000081, word1=0x0000000A, 48 words total, last_o on word 48.
REQ-029 lvl2, ready_o=0 for the first 40 cycles -> word0 held stable with valid_o=1; ready_i=0 once cnt reaches 32; on release, the stream is bit-identical to the no-stall stream.
REQ-030 lvl2, coefficient 44 at index 3 -> err_o=1 after that edge and held through the polynomial; word0 bits [23:18] = 6'd44.
REQ-031 Assert rst after 100 lvl3 coefficients, then send a full lvl2 polynomial -> outputs are 0 during reset; afterwards exactly 48 correct words, and the word count is not offset by the aborted data.
REQ-032 Change sec_lvl from 2 to 5 at coefficient 128 -> packing stays 6-bit to the end (48 words); the next polynomial packs 4-bit (32 words).

Source files
------------

// File: rtl/w1_packer.sv
// SimpleBitPack of one 256-coefficient w1 polynomial into little-endian 32-bit words.
// Coefficients are 6 bits wide (level 2) or 4 bits wide (levels 3/5).
module w1_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  sec_lvl,
    input  logic        valid_i,
    input  logic [23:0] di,
    output logic        ready_i,
    output logic [31:0] do_o,
    output logic        valid_o,
    input  logic        ready_o,
    output logic        last_o,
    output logic        err_o
);

    localparam logic [2:0] W6 = 3'd6;
    localparam logic [2:0] W4 = 3'd4;

    logic [63:0] acc_q, acc_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  ccnt_q, ccnt_d;
    logic [5:0]  wcnt_q, wcnt_d;
    logic [2:0]  w_q, w_d;
    logic [31:0] do_q, do_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        err_q, err_d;

    logic [2:0]  lvl_w;
    logic [2:0]  cur_w;
    logic [5:0]  coef;
    logic        range_bad;
    logic [5:0]  last_idx;
    logic        in_fire;
    logic        emit;

    // Width is taken from sec_lvl only on coefficient 0; afterwards the latched width rules.
    always_comb begin
        lvl_w     = (sec_lvl == 3'd3 || sec_lvl == 3'd5) ? W4 : W6;
        cur_w     = (ccnt_q == 8'd0) ? lvl_w : w_q;
        coef      = (cur_w == W4) ? {2'b00, di[3:0]} : di[5:0];
        range_bad = (cur_w == W4) ? (di[5:0] > 6'd15) : (di[5:0] > 6'd43);
        last_idx  = (w_q == W4) ? 6'd31 : 6'd47;
    end

    // Registers-only ready; input and emit are mutually exclusive because both key off cnt.
    assign ready_i = (cnt_q < 6'd32);
    assign in_fire = valid_i && ready_i;
    assign emit    = !ready_i && (!valid_q || ready_o);

    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ccnt_d  = ccnt_q;
        wcnt_d  = wcnt_q;
        w_d     = w_q;
        do_d    = do_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q;

        if (in_fire) begin
            acc_d  = acc_q | ({58'd0, coef} << cnt_q);
            cnt_d  = cnt_q + {3'd0, cur_w};
            ccnt_d = ccnt_q + 8'd1;
            w_d    = cur_w;
            err_d  = err_q | range_bad;
        end

        if (emit) begin
            do_d    = acc_q[31:0];
            valid_d = 1'b1;
            last_d  = (wcnt_q == last_idx);
            acc_d   = acc_q >> 32;
            cnt_d   = cnt_q - 6'd32;
            wcnt_d  = (wcnt_q == last_idx) ? 6'd0 : wcnt_q + 6'd1;
        end else if (valid_q && ready_o) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            ccnt_q  <= '0;
            wcnt_q  <= '0;
            w_q     <= W6;
            do_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ccnt_q  <= ccnt_d;
            wcnt_q  <= wcnt_d;
            w_q     <= w_d;
            do_q    <= do_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign do_o    = do_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign err_o   = err_q;

endmodule
